// File: rtl/kgp_control_fsm.sv
// Multi-cycle control unit for the KGP-RISC core: fetch/decode/execute/memory/write-back
// sequencing, memory handshake, and a retired-instruction counter.
module kgp_control_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [10:0] opcode_ext,
    input  logic        flag_zero,
    input  logic        flag_carry,
    input  logic        flag_sign,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_load,
    output logic        mdr_load,
    output logic        pc_load,
    output logic        flags_load,
    output logic        reg_we,
    output logic [1:0]  pc_src,
    output logic        alu_src_imm,
    output logic [3:0]  alu_op,
    output logic        reg_wsel,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal_op,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        ERR    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        K_ALU = 2'd0,
        K_LW  = 2'd1,
        K_SW  = 2'd2,
        K_BR  = 2'd3
    } kind_t;

    state_t      cur_state;
    state_t      next_state;
    kind_t       kind_q;
    kind_t       dec_kind;
    kind_t       next_kind;
    logic [3:0]  alu_op_q;
    logic [3:0]  dec_alu_op;
    logic [3:0]  next_alu_op;
    logic        imm_q;
    logic        dec_imm;
    logic        next_imm;
    logic        dec_legal;
    logic        dec_halt;
    logic [3:0]  br_op_q;
    logic        branch_exec;
    logic        br_cond;
    logic        br_taken;
    logic        mem_done;
    logic        retire_now;
    logic        alu_phase;
    logic        unused_ext;

    assign unused_ext = ^opcode_ext[10:4];

    always_comb begin
        dec_kind   = K_ALU;
        dec_alu_op = 4'd0;
        dec_imm    = 1'b0;
        dec_legal  = 1'b1;
        dec_halt   = 1'b0;
        case (opcode)
            6'b000000: begin
                dec_alu_op = opcode_ext[3:0];
                dec_legal  = ~opcode_ext[3];
            end
            6'b000001: dec_imm = 1'b1;
            6'b000010: begin
                dec_alu_op = 4'd8;
                dec_imm    = 1'b1;
            end
            6'b000011: begin
                dec_kind = K_LW;
                dec_imm  = 1'b1;
            end
            6'b000100: begin
                dec_kind = K_SW;
                dec_imm  = 1'b1;
            end
            6'b000101, 6'b000110, 6'b000111, 6'b001000, 6'b001001: dec_kind = K_BR;
            6'b111111: dec_halt = 1'b1;
            default:   dec_legal = 1'b0;
        endcase
    end

    // Registered outputs are computed for the state being entered, so the
    // instruction attributes come straight from the decoder while in DECODE.
    assign next_kind   = (cur_state == DECODE) ? dec_kind   : kind_q;
    assign next_alu_op = (cur_state == DECODE) ? dec_alu_op : alu_op_q;
    assign next_imm    = (cur_state == DECODE) ? dec_imm    : imm_q;
    assign mem_done    = mem_req & mem_ready;
    assign alu_phase   = (next_state == EXEC) || (next_state == MEM);

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            FETCH:  if (mem_done) next_state = DECODE;
            DECODE: begin
                if (!dec_legal)    next_state = ERR;
                else if (dec_halt) next_state = HALT;
                else               next_state = EXEC;
            end
            EXEC: begin
                case (kind_q)
                    K_ALU:      next_state = WB;
                    K_LW, K_SW: next_state = MEM;
                    default:    next_state = FETCH;
                endcase
            end
            MEM:    if (mem_done) next_state = (kind_q == K_LW) ? WB : FETCH;
            WB:     next_state = FETCH;
            HALT:   next_state = HALT;
            ERR:    next_state = ERR;
            default: next_state = ERR;
        endcase
    end

    always_comb begin
        case (br_op_q)
            4'd5:    br_cond = 1'b1;
            4'd6:    br_cond = flag_zero;
            4'd7:    br_cond = ~flag_zero;
            4'd8:    br_cond = flag_carry;
            4'd9:    br_cond = flag_sign;
            default: br_cond = 1'b0;
        endcase
    end

    // Load strobes that depend on same-cycle mem_ready or flags stay combinational.
    assign br_taken = branch_exec & br_cond;
    assign ir_load  = mem_done & ~mem_addr_sel;
    assign mdr_load = mem_done & mem_addr_sel & ~mem_we;
    assign pc_load  = ir_load | br_taken;
    assign pc_src   = br_taken ? 2'b01 : 2'b00;
    assign state    = cur_state;

    assign retire_now = (cur_state == WB)
                      | ((cur_state == MEM) & mem_done & (kind_q == K_SW))
                      | ((cur_state == EXEC) & (kind_q == K_BR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state    <= FETCH;
            kind_q       <= K_ALU;
            alu_op_q     <= 4'd0;
            imm_q        <= 1'b0;
            br_op_q      <= 4'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr_sel <= 1'b0;
            alu_op       <= 4'd0;
            alu_src_imm  <= 1'b0;
            flags_load   <= 1'b0;
            reg_we       <= 1'b0;
            reg_wsel     <= 1'b0;
            branch_exec  <= 1'b0;
            halted       <= 1'b0;
            illegal_op   <= 1'b0;
            retired      <= 32'd0;
        end else begin
            cur_state <= next_state;
            if (cur_state == DECODE) begin
                kind_q   <= dec_kind;
                alu_op_q <= dec_alu_op;
                imm_q    <= dec_imm;
                br_op_q  <= opcode[3:0];
            end
            mem_req      <= (next_state == FETCH) || (next_state == MEM);
            mem_addr_sel <= (next_state == MEM);
            mem_we       <= (next_state == MEM) && (next_kind == K_SW);
            alu_op       <= alu_phase ? next_alu_op : 4'd0;
            alu_src_imm  <= alu_phase && next_imm;
            flags_load   <= (next_state == EXEC) && (next_kind == K_ALU);
            reg_we       <= (next_state == WB);
            reg_wsel     <= (next_state == WB) && (next_kind == K_LW);
            branch_exec  <= (next_state == EXEC) && (next_kind == K_BR);
            halted       <= (next_state == HALT);
            illegal_op   <= (next_state == ERR);
            if (retire_now) retired <= retired + 32'd1;
        end
    end

endmodule

// File: tb/tb_kgp_control_fsm.sv
// Table-driven check of kgp_control_fsm: a per-cycle program of vectors, then
// hand-written reset, illegal-opcode and halt-exit sequences.
module tb_kgp_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [10:0] opcode_ext;
    logic        flag_zero, flag_carry, flag_sign, mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_load, mdr_load, pc_load;
    logic        flags_load, reg_we, alu_src_imm, reg_wsel, halted, illegal_op;
    logic [1:0]  pc_src;
    logic [3:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] retired;

    typedef struct packed {
        logic [5:0]  opc;
        logic [10:0] ext;
        logic [2:0]  flg;
        logic        rdy;
    } ins_t;

    typedef struct packed {
        logic [2:0]  st;
        logic        req, we, asel, irl, mdrl, pcl, fl, rwe, rws, imm, hlt, ill;
        logic [1:0]  psrc;
        logic [3:0]  aop;
        logic [31:0] ret;
    } outs_t;

    typedef struct packed {
        ins_t  in;
        outs_t exp;
    } vec_t;

    // Bit order: req we asel irl mdrl pcl fl rwe rws imm hlt ill
    localparam logic [11:0] NONE   = 12'b000000_000000;
    localparam logic [11:0] F_RDY  = 12'b100101_000000;
    localparam logic [11:0] F_WAIT = 12'b100000_000000;
    localparam logic [11:0] EX_R   = 12'b000000_100000;
    localparam logic [11:0] EX_I   = 12'b000000_100100;
    localparam logic [11:0] EX_M   = 12'b000000_000100;
    localparam logic [11:0] M_WAIT = 12'b101000_000100;
    localparam logic [11:0] M_LW   = 12'b101010_000100;
    localparam logic [11:0] M_SW   = 12'b111000_000100;
    localparam logic [11:0] WB_A   = 12'b000000_010000;
    localparam logic [11:0] WB_L   = 12'b000000_011000;
    localparam logic [11:0] BR_T   = 12'b000001_000000;
    localparam logic [11:0] HLT    = 12'b000000_000010;

    localparam logic [5:0] OP_R = 6'd0, OP_ADDI = 6'd1, OP_COMPI = 6'd2, OP_LW = 6'd3;
    localparam logic [5:0] OP_SW = 6'd4, OP_BZ = 6'd6, OP_BNZ = 6'd7, OP_BCY = 6'd8;
    localparam logic [5:0] OP_BNEG = 6'd9, OP_HALT = 6'd63;

    vec_t vecs[$];
    int   applied = 0;
    int   miscompares = 0;

    kgp_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .opcode_ext(opcode_ext),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_sign(flag_sign),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_load(ir_load), .mdr_load(mdr_load),
        .pc_load(pc_load), .flags_load(flags_load), .reg_we(reg_we), .pc_src(pc_src),
        .alu_src_imm(alu_src_imm), .alu_op(alu_op), .reg_wsel(reg_wsel),
        .state(state), .halted(halted), .illegal_op(illegal_op), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic addVec(input logic [5:0] opc, input logic [10:0] ext, input logic [2:0] flg,
                          input logic rdy, input logic [2:0] st, input logic [11:0] bits,
                          input logic [1:0] psrc, input logic [3:0] aop, input logic [31:0] ret);
        vec_t v;
        v.in.opc = opc;
        v.in.ext = ext;
        v.in.flg = flg;
        v.in.rdy = rdy;
        v.exp.st = st;
        {v.exp.req, v.exp.we, v.exp.asel, v.exp.irl, v.exp.mdrl, v.exp.pcl,
         v.exp.fl, v.exp.rwe, v.exp.rws, v.exp.imm, v.exp.hlt, v.exp.ill} = bits;
        v.exp.psrc = psrc;
        v.exp.aop  = aop;
        v.exp.ret  = ret;
        vecs.push_back(v);
    endtask

    function automatic outs_t sampleOutputs();
        outs_t o;
        o.st = state;
        {o.req, o.we, o.asel, o.irl, o.mdrl, o.pcl, o.fl, o.rwe, o.rws, o.imm, o.hlt, o.ill} =
            {mem_req, mem_we, mem_addr_sel, ir_load, mdr_load, pc_load,
             flags_load, reg_we, reg_wsel, alu_src_imm, halted, illegal_op};
        o.psrc = pc_src;
        o.aop  = alu_op;
        o.ret  = retired;
        return o;
    endfunction

    task automatic applyStimulus(input ins_t i);
        opcode     = i.opc;
        opcode_ext = i.ext;
        {flag_zero, flag_carry, flag_sign} = i.flg;
        mem_ready  = i.rdy;
    endtask

    task automatic checkOutput(input int idx, input outs_t exp);
        outs_t act;
        act = sampleOutputs();
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL vec%0d: got %h, want %h", idx, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus('0);

        // R-type ext=3, zero wait (first row: mem_ready ignored while mem_req=0)
        addVec(OP_R, 11'd3, 3'b000, 1'b1, 3'd0, NONE,   2'b00, 4'd0, 32'd0);
        addVec(OP_R, 11'd3, 3'b000, 1'b1, 3'd0, F_RDY,  2'b00, 4'd0, 32'd0);
        addVec(OP_R, 11'd3, 3'b000, 1'b0, 3'd1, NONE,   2'b00, 4'd0, 32'd0);
        addVec(OP_R, 11'd3, 3'b000, 1'b0, 3'd2, EX_R,   2'b00, 4'd3, 32'd0);
        addVec(OP_R, 11'd3, 3'b000, 1'b0, 3'd4, WB_A,   2'b00, 4'd0, 32'd0);
        // lw with two wait cycles in both FETCH and MEM
        addVec(OP_LW, 11'd0, 3'b000, 1'b0, 3'd0, F_WAIT, 2'b00, 4'd0, 32'd1);
        addVec(OP_LW, 11'd0, 3'b000, 1'b0, 3'd0, F_WAIT, 2'b00, 4'd0, 32'd1);
        addVec(OP_LW, 11'd0, 3'b000, 1'b1, 3'd0, F_RDY,  2'b00, 4'd0, 32'd1);
        addVec(OP_LW, 11'd0, 3'b000, 1'b0, 3'd1, NONE,   2'b00, 4'd0, 32'd1);
        addVec(OP_LW, 11'd0, 3'b000, 1'b0, 3'd2, EX_M,   2'b00, 4'd0, 32'd1);
        addVec(OP_LW, 11'd0, 3'b000, 1'b0, 3'd3, M_WAIT, 2'b00, 4'd0, 32'd1);
        addVec(OP_LW, 11'd0, 3'b000, 1'b0, 3'd3, M_WAIT, 2'b00, 4'd0, 32'd1);
        addVec(OP_LW, 11'd0, 3'b000, 1'b1, 3'd3, M_LW,   2'b00, 4'd0, 32'd1);
        addVec(OP_LW, 11'd0, 3'b000, 1'b0, 3'd4, WB_L,   2'b00, 4'd0, 32'd1);
        // sw zero wait; FETCH follows MEM directly
        addVec(OP_SW, 11'd0, 3'b000, 1'b1, 3'd0, F_RDY,  2'b00, 4'd0, 32'd2);
        addVec(OP_SW, 11'd0, 3'b000, 1'b0, 3'd1, NONE,   2'b00, 4'd0, 32'd2);
        addVec(OP_SW, 11'd0, 3'b000, 1'b0, 3'd2, EX_M,   2'b00, 4'd0, 32'd2);
        addVec(OP_SW, 11'd0, 3'b000, 1'b1, 3'd3, M_SW,   2'b00, 4'd0, 32'd2);
        // addi with junk in opcode_ext, which must be ignored
        addVec(OP_ADDI, 11'h7F5, 3'b000, 1'b1, 3'd0, F_RDY, 2'b00, 4'd0, 32'd3);
        addVec(OP_ADDI, 11'h7F5, 3'b000, 1'b0, 3'd1, NONE,  2'b00, 4'd0, 32'd3);
        addVec(OP_ADDI, 11'h7F5, 3'b000, 1'b0, 3'd2, EX_I,  2'b00, 4'd0, 32'd3);
        addVec(OP_ADDI, 11'h7F5, 3'b000, 1'b0, 3'd4, WB_A,  2'b00, 4'd0, 32'd3);
        // bz taken, bz not taken, bnz taken, bcy taken, bneg not taken
        addVec(OP_BZ, 11'd0, 3'b100, 1'b1, 3'd0, F_RDY, 2'b00, 4'd0, 32'd4);
        addVec(OP_BZ, 11'd0, 3'b100, 1'b0, 3'd1, NONE,  2'b00, 4'd0, 32'd4);
        addVec(OP_BZ, 11'd0, 3'b100, 1'b0, 3'd2, BR_T,  2'b01, 4'd0, 32'd4);
        addVec(OP_BZ, 11'd0, 3'b000, 1'b1, 3'd0, F_RDY, 2'b00, 4'd0, 32'd5);
        addVec(OP_BZ, 11'd0, 3'b000, 1'b0, 3'd1, NONE,  2'b00, 4'd0, 32'd5);
        addVec(OP_BZ, 11'd0, 3'b000, 1'b0, 3'd2, NONE,  2'b00, 4'd0, 32'd5);
        addVec(OP_BNZ, 11'd0, 3'b000, 1'b1, 3'd0, F_RDY, 2'b00, 4'd0, 32'd6);
        addVec(OP_BNZ, 11'd0, 3'b000, 1'b0, 3'd1, NONE,  2'b00, 4'd0, 32'd6);
        addVec(OP_BNZ, 11'd0, 3'b000, 1'b0, 3'd2, BR_T,  2'b01, 4'd0, 32'd6);
        addVec(OP_BCY, 11'd0, 3'b110, 1'b1, 3'd0, F_RDY, 2'b00, 4'd0, 32'd7);
        addVec(OP_BCY, 11'd0, 3'b110, 1'b0, 3'd1, NONE,  2'b00, 4'd0, 32'd7);
        addVec(OP_BCY, 11'd0, 3'b110, 1'b0, 3'd2, BR_T,  2'b01, 4'd0, 32'd7);
        addVec(OP_BNEG, 11'd0, 3'b110, 1'b1, 3'd0, F_RDY, 2'b00, 4'd0, 32'd8);
        addVec(OP_BNEG, 11'd0, 3'b110, 1'b0, 3'd1, NONE,  2'b00, 4'd0, 32'd8);
        addVec(OP_BNEG, 11'd0, 3'b110, 1'b0, 3'd2, NONE,  2'b00, 4'd0, 32'd8);
        // compi, then R-type with the highest legal extension
        addVec(OP_COMPI, 11'd0, 3'b000, 1'b1, 3'd0, F_RDY, 2'b00, 4'd0, 32'd9);
        addVec(OP_COMPI, 11'd0, 3'b000, 1'b0, 3'd1, NONE,  2'b00, 4'd0, 32'd9);
        addVec(OP_COMPI, 11'd0, 3'b000, 1'b0, 3'd2, EX_I,  2'b00, 4'd8, 32'd9);
        addVec(OP_COMPI, 11'd0, 3'b000, 1'b0, 3'd4, WB_A,  2'b00, 4'd0, 32'd9);
        addVec(OP_R, 11'd7, 3'b000, 1'b1, 3'd0, F_RDY, 2'b00, 4'd0, 32'd10);
        addVec(OP_R, 11'd7, 3'b000, 1'b0, 3'd1, NONE,  2'b00, 4'd0, 32'd10);
        addVec(OP_R, 11'd7, 3'b000, 1'b0, 3'd2, EX_R,  2'b00, 4'd7, 32'd10);
        addVec(OP_R, 11'd7, 3'b000, 1'b0, 3'd4, WB_A,  2'b00, 4'd0, 32'd10);
        // halt: absorbing, mem_ready ignored
        addVec(OP_HALT, 11'd0, 3'b000, 1'b1, 3'd0, F_RDY, 2'b00, 4'd0, 32'd11);
        addVec(OP_HALT, 11'd0, 3'b000, 1'b0, 3'd1, NONE,  2'b00, 4'd0, 32'd11);
        addVec(OP_HALT, 11'd0, 3'b000, 1'b0, 3'd5, HLT,   2'b00, 4'd0, 32'd11);
        addVec(OP_HALT, 11'd0, 3'b000, 1'b1, 3'd5, HLT,   2'b00, 4'd0, 32'd11);
        addVec(OP_HALT, 11'd0, 3'b111, 1'b1, 3'd5, HLT,   2'b00, 4'd0, 32'd11);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].in);
            #1;
            checkOutput(i, vecs[i].exp);
            @(negedge clk);
        end

        // Reset from HALT, then asynchronous reset in the middle of a FETCH request
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checkValue("haltRstState", {29'd0, state}, 32'd0);
        checkValue("haltRstHalted", {31'd0, halted}, 32'd0);
        checkValue("haltRstRetired", retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkValue("relReqLow", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        checkValue("relReqRise", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("midFetchReq", {31'd0, mem_req}, 32'd0);
        checkValue("midFetchIrLoad", {31'd0, ir_load}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkValue("relState", {29'd0, state}, 32'd0);
        checkValue("relRetired", retired, 32'd0);
        @(posedge clk);
        #1;
        checkValue("relReqRise2", {31'd0, mem_req}, 32'd1);

        // Illegal opcode 001111
        opcode = 6'b001111;
        opcode_ext = 11'd0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkValue("illOpState", {29'd0, state}, 32'd6);
        checkValue("illOpFlag", {31'd0, illegal_op}, 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkValue("illOpReqLow", {31'd0, mem_req}, 32'd0);
        end
        checkValue("illOpRetired", retired, 32'd0);

        // R-type with illegal extension 9
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        opcode = OP_R;
        opcode_ext = 11'd9;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkValue("illExtState", {29'd0, state}, 32'd6);
        checkValue("illExtFlag", {31'd0, illegal_op}, 32'd1);
        checkValue("illExtReq", {31'd0, mem_req}, 32'd0);
        checkValue("illExtRetired", retired, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
